// File: rtl/flit_gen_pkg.sv
// Shared definitions for the flit traffic generator.
// Holds the FSM state encoding, the write-flit width, the write opcode,
// the bit positions of the wr_data fields and the payload pattern helper.
package flit_gen_pkg;

    localparam int FLIT_W = 528;

    localparam logic [15:0] OPC_WR = 16'h0001;

    // wr_data field positions
    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 15;
    localparam int IDX_LSB = 16;
    localparam int IDX_MSB = 31;
    localparam int PAT_LSB = 128;
    localparam int PAT_MSB = 255;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_READ     = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Pattern word for one flit: base plus zero-extended index, wrapping mod 2^32.
    function automatic logic [31:0] pattern_word(input logic [31:0] base,
                                                 input logic [31:0] idx);
        return base + idx;
    endfunction

endpackage

// File: rtl/flit_payload_fmt.sv
// Combinational formatter: builds the 528-bit write flit from a flit index.
// Ports:
//   i_idx   in  IDX_W    flit index
//   o_data  out FLIT_W   formatted flit (pattern x4, index, write opcode)
module flit_payload_fmt
    import flit_gen_pkg::*;
#(
    parameter int          IDX_W        = 7,
    parameter logic [31:0] PATTERN_BASE = 32'hA5A5_0000
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [FLIT_W-1:0] o_data
);

    logic [31:0] w_pat;

    assign w_pat = pattern_word(PATTERN_BASE, 32'(i_idx));

    // Assemble the flit fields; everything not named stays zero.
    always_comb begin
        o_data                   = '0;
        o_data[PAT_MSB:PAT_LSB]  = {4{w_pat}};
        o_data[IDX_MSB:IDX_LSB]  = 16'(i_idx);
        o_data[OPC_MSB:OPC_LSB]  = OPC_WR;
    end

endmodule

// File: rtl/flit_traffic_gen.sv
// Flit traffic generator: issues NUM_FLITS write flits, then NUM_FLITS read
// requests, counts the returning read responses and raises wr_rd_done when
// all are back.
// Optional watchdog: define FLIT_TRAFFIC_GEN_TIMEOUT_EN to build a counter
// that forces DONE and sets timeout_err after TIMEOUT_CYCLES idle busy cycles.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               one-cycle start pulse (honoured in IDLE/DONE only)
//   wr_valid/ready/data write flit handshake and 528-bit payload
//   rd_valid/ready/addr read request handshake and 16-bit index
//   drs_valid           one read response per cycle
//   wr_rd_done          level, all responses received
//   busy                high in WRITE, READ, WAIT_RSP
//   rsp_overflow        sticky, response beyond NUM_FLITS
//   timeout_err         sticky watchdog error (0 without the macro)
module flit_traffic_gen
    import flit_gen_pkg::*;
#(
    parameter int          NUM_FLITS      = 64,
    parameter logic [31:0] PATTERN_BASE   = 32'hA5A5_0000,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [FLIT_W-1:0]  wr_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [15:0]        rd_addr,
    input  logic               drs_valid,
    output logic               wr_rd_done,
    output logic               busy,
    output logic               rsp_overflow,
    output logic               timeout_err
);

    localparam int             CW     = $clog2(NUM_FLITS + 1);
    localparam logic [CW-1:0]  N_C    = CW'(NUM_FLITS);
    localparam logic [CW-1:0]  N_M1_C = CW'(NUM_FLITS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_wr_cnt;
    logic [CW-1:0]       r_rd_cnt;
    logic [CW-1:0]       r_rsp_cnt;
    logic [CW-1:0]       w_rsp_cnt_nxt;
    logic                r_rsp_overflow;
    logic                w_start_ok;
    logic                w_wr_xfer;
    logic                w_rd_xfer;
    logic                w_busy;
    logic                w_rsp_window;
    logic                w_timeout;
    logic [FLIT_W-1:0]   w_flit;

    assign w_busy       = (r_state == ST_WRITE) || (r_state == ST_READ) ||
                          (r_state == ST_WAIT_RSP);
    assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // valid is a pure decode of state, so a transfer is state && ready
    assign w_wr_xfer    = (r_state == ST_WRITE) && wr_ready;
    assign w_rd_xfer    = (r_state == ST_READ) && rd_ready;
    assign w_rsp_window = (r_state == ST_READ) || (r_state == ST_WAIT_RSP);

`ifdef FLIT_TRAFFIC_GEN_TIMEOUT_EN
    localparam int            TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_C = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_wdog;
    logic          r_timeout_err;

    assign w_timeout   = w_busy && (r_wdog == TO_C);
    assign timeout_err = r_timeout_err;

    // Watchdog: restarts on any progress, counts while busy, saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (w_wr_xfer || w_rd_xfer || drs_valid || !w_busy) begin
            r_wdog <= '0;
        end else if (r_wdog != TO_C) begin
            r_wdog <= r_wdog + TW'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset or an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_start_ok) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Response count after this cycle; saturates at NUM_FLITS.
    always_comb begin
        w_rsp_cnt_nxt = r_rsp_cnt;
        if (w_rsp_window && drs_valid && (r_rsp_cnt != N_C)) begin
            w_rsp_cnt_nxt = r_rsp_cnt + CW'(1);
        end else begin
            w_rsp_cnt_nxt = r_rsp_cnt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_WRITE;
                else            w_state_nxt = ST_IDLE;
            end
            ST_WRITE: begin
                if (w_timeout)                           w_state_nxt = ST_DONE;
                else if (w_wr_xfer && r_wr_cnt == N_M1_C) w_state_nxt = ST_READ;
                else                                     w_state_nxt = ST_WRITE;
            end
            ST_READ: begin
                if (w_timeout)                           w_state_nxt = ST_DONE;
                else if (w_rd_xfer && r_rd_cnt == N_M1_C) w_state_nxt = ST_WAIT_RSP;
                else                                     w_state_nxt = ST_READ;
            end
            ST_WAIT_RSP: begin
                // the cycle carrying the final response already counts as complete
                if (w_timeout)                 w_state_nxt = ST_DONE;
                else if (w_rsp_cnt_nxt == N_C) w_state_nxt = ST_DONE;
                else                           w_state_nxt = ST_WAIT_RSP;
            end
            ST_DONE: begin
                if (w_start_ok) w_state_nxt = ST_WRITE;
                else            w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transfer/response counters and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_rsp_cnt      <= '0;
            r_rsp_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_wr_cnt       <= '0;
            r_rd_cnt       <= '0;
            r_rsp_cnt      <= '0;
            r_rsp_overflow <= 1'b0;
        end else begin
            if (w_wr_xfer) r_wr_cnt <= r_wr_cnt + CW'(1);
            if (w_rd_xfer) r_rd_cnt <= r_rd_cnt + CW'(1);
            r_rsp_cnt <= w_rsp_cnt_nxt;
            if ((r_state == ST_WAIT_RSP) && drs_valid && (r_rsp_cnt == N_C)) begin
                r_rsp_overflow <= 1'b1;
            end
        end
    end

    flit_payload_fmt #(
        .IDX_W        (CW),
        .PATTERN_BASE (PATTERN_BASE)
    ) u_fmt (
        .i_idx  (r_wr_cnt),
        .o_data (w_flit)
    );

    // FSM outputs, decoded from registered state and counters only.
    always_comb begin
        wr_valid   = 1'b0;
        rd_valid   = 1'b0;
        wr_rd_done = 1'b0;
        wr_data    = '0;
        rd_addr    = 16'h0000;
        case (r_state)
            ST_WRITE: begin
                wr_valid = 1'b1;
                wr_data  = w_flit;
            end
            ST_READ: begin
                rd_valid = 1'b1;
                rd_addr  = 16'(r_rd_cnt);
            end
            ST_DONE: begin
                wr_rd_done = 1'b1;
            end
            default: begin
                wr_valid = 1'b0;
            end
        endcase
    end

    assign busy         = w_busy;
    assign rsp_overflow = r_rsp_overflow;

endmodule

// File: tb/tb_flit_traffic_gen.sv
// Directed self-checking bench for flit_traffic_gen with NUM_FLITS=4.
module tb_flit_traffic_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         wr_valid;
    logic         wr_ready;
    logic [527:0] wr_data;
    logic         rd_valid;
    logic         rd_ready;
    logic [15:0]  rd_addr;
    logic         drs_valid;
    logic         wr_rd_done;
    logic         busy;
    logic         rsp_overflow;
    logic         timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    flit_traffic_gen #(
        .NUM_FLITS      (4),
        .PATTERN_BASE   (32'hA5A5_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .drs_valid    (drs_valid),
        .wr_rd_done   (wr_rd_done),
        .busy         (busy),
        .rsp_overflow (rsp_overflow),
        .timeout_err  (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [527:0] obs, input logic [527:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [527:0] exp_flit(input int idx);
        logic [527:0] d;
        logic [31:0]  p;
        p = 32'hA5A5_0000 + 32'(idx);
        d = '0;
        d[255:128] = {p, p, p, p};
        d[31:16]   = 16'(idx);
        d[15:0]    = 16'h0001;
        return d;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_valid"}, 528'(wr_valid), 528'(0));
        chk({tag, "_rd_valid"}, 528'(rd_valid), 528'(0));
        chk({tag, "_done"},     528'(wr_rd_done), 528'(0));
        chk({tag, "_busy"},     528'(busy), 528'(0));
        chk({tag, "_ovf"},      528'(rsp_overflow), 528'(0));
        chk({tag, "_tmo"},      528'(timeout_err), 528'(0));
        chk({tag, "_wr_data"},  wr_data, 528'(0));
        chk({tag, "_rd_addr"},  528'(rd_addr), 528'(0));
    endtask

    initial begin
        int w;
        reset = 1'b1; start = 1'b0; wr_ready = 1'b1; rd_ready = 1'b1; drs_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_idle("reset");

        // Basic run: full-rate writes, reads, then four responses in WAIT_RSP.
        start = 1'b1; tick(); start = 1'b0;
        chk("t1_busy", 528'(busy), 528'(1));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_wv%0d", i), 528'(wr_valid), 528'(1));
            chk($sformatf("t1_wd%0d", i), wr_data, exp_flit(i));
            tick();
        end
        chk("t1_wv_drop", 528'(wr_valid), 528'(0));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t1_rv%0d", j), 528'(rd_valid), 528'(1));
            chk($sformatf("t1_ra%0d", j), 528'(rd_addr), 528'(j));
            tick();
        end
        chk("t1_rv_drop", 528'(rd_valid), 528'(0));
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_wait%0d_busy", k), 528'(busy), 528'(1));
            chk($sformatf("t1_wait%0d_done", k), 528'(wr_rd_done), 528'(0));
            drs_valid = 1'b1; tick();
        end
        drs_valid = 1'b0;
        chk("t1_done", 528'(wr_rd_done), 528'(1));
        chk("t1_done_busy", 528'(busy), 528'(0));
        chk("t1_ovf", 528'(rsp_overflow), 528'(0));
        tick();
        chk("t1_done_hold", 528'(wr_rd_done), 528'(1));

        // Write stall mid-burst; responses all arrive during READ; extra response.
        start = 1'b1; tick(); start = 1'b0;
        chk("t2_done_clr", 528'(wr_rd_done), 528'(0));
        chk("t2_wd0", wr_data, exp_flit(0));
        tick();
        wr_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("t2_stall%0d_wv", s), 528'(wr_valid), 528'(1));
            chk($sformatf("t2_stall%0d_wd", s), wr_data, exp_flit(1));
        end
        wr_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("t2_wd%0d", i), wr_data, exp_flit(i));
            tick();
        end
        chk("t2_read_rv", 528'(rd_valid), 528'(1));
        chk("t2_read_wv", 528'(wr_valid), 528'(0));
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t3_ra%0d", j), 528'(rd_addr), 528'(j));
            drs_valid = 1'b1; tick();
        end
        // WAIT_RSP with all four responses counted; a fifth arrives now
        chk("t3_wait_busy", 528'(busy), 528'(1));
        chk("t3_wait_done", 528'(wr_rd_done), 528'(0));
        tick();
        drs_valid = 1'b0;
        chk("t4_done", 528'(wr_rd_done), 528'(1));
        chk("t4_ovf", 528'(rsp_overflow), 528'(1));
        tick();
        chk("t4_ovf_sticky", 528'(rsp_overflow), 528'(1));

        // Restart clears overflow; reset mid-WRITE; start ignored while busy.
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_ovf_clr", 528'(rsp_overflow), 528'(0));
        tick(); tick();
        chk("t5_wd2", wr_data, exp_flit(2));
        reset = 1'b1; tick(); reset = 1'b0;
        chk_idle("t5_reset");
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_rerun_wd0", wr_data, exp_flit(0));
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_start_ignored", wr_data, exp_flit(2));
        rd_ready = 1'b0;
        tick(); tick();
        chk("t6_read_rv", 528'(rd_valid), 528'(1));

`ifdef FLIT_TRAFFIC_GEN_TIMEOUT_EN
        w = 0;
        while (!wr_rd_done && w < 40) begin
            tick();
            w++;
        end
        chk("t6_tmo_done", 528'(wr_rd_done), 528'(1));
        chk("t6_tmo_err", 528'(timeout_err), 528'(1));
        chk("t6_tmo_rv", 528'(rd_valid), 528'(0));
        chk("t6_tmo_late_enough", 528'(w >= 16), 528'(1));
`else
        w = 0;
        repeat (20) begin
            tick();
            w++;
        end
        chk("t6_stuck_busy", 528'(busy), 528'(1));
        chk("t6_stuck_rv", 528'(rd_valid), 528'(1));
        chk("t6_stuck_ra", 528'(rd_addr), 528'(0));
        chk("t6_stuck_tmo", 528'(timeout_err), 528'(0));
        chk("t6_stuck_done", 528'(wr_rd_done), 528'(0));
`endif

        rd_ready = 1'b1;
        reset = 1'b1; tick(); reset = 1'b0;
        chk_idle("final_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
